// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Define PIPELINED_CLA_SUB_EN to add the io_in_sub subtract input.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic             io_in_c_in,
`ifdef PIPELINED_CLA_SUB_EN
  input  logic             io_in_sub,
`endif
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_s,
  output logic             io_out_c_out,
  output logic             io_out_pg,
  output logic             io_out_gg,
  output logic             io_out_ovf
);

  localparam int NB = WIDTH / BLOCK;

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

`ifdef PIPELINED_CLA_SUB_EN
  assign b_eff = io_in_sub ? ~io_in_b : io_in_b;
  assign c_eff = io_in_sub | io_in_c_in;
`else
  assign b_eff = io_in_b;
  assign c_eff = io_in_c_in;
`endif

  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] g_d;
  logic [NB-1:0]    bpg_d;
  logic [NB-1:0]    bgg_d;

  assign p_d = io_in_a | b_eff;
  assign g_d = io_in_a & b_eff;

  always_comb begin
    logic t;
    bpg_d = '0;
    bgg_d = '0;
    for (int k = 0; k < NB; k++) begin
      t = 1'b0;
      for (int i = 0; i < BLOCK; i++)
        t = (t & p_d[k*BLOCK+i]) | g_d[k*BLOCK+i];
      bpg_d[k] = &p_d[k*BLOCK +: BLOCK];
      bgg_d[k] = t;
    end
  end

  logic             s1_valid;
  logic             s1_cin;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic [NB-1:0]    s1_bpg;
  logic [NB-1:0]    s1_bgg;
  logic             stage1_advance;

  assign stage1_advance = !io_out_valid | io_out_ready;
  assign io_in_ready    = !s1_valid | stage1_advance;

  // Operand registers carry no reset; only the valid bits gate them.
  always_ff @(posedge clock) begin
    if (io_in_ready && io_in_valid) begin
      s1_cin <= c_eff;
      s1_x   <= io_in_a ^ b_eff;
      s1_p   <= p_d;
      s1_g   <= g_d;
      s1_bpg <= bpg_d;
      s1_bgg <= bgg_d;
    end
  end

  logic [WIDTH-1:0] carry;
  logic             w_pg;
  logic             w_gg;
  logic             c_out_d;

  always_comb begin
    logic cb;
    logic c;
    carry = '0;
    cb    = s1_cin;
    c     = 1'b0;
    w_pg  = 1'b1;
    w_gg  = 1'b0;
    for (int k = 0; k < NB; k++) begin
      c = cb;
      for (int i = 0; i < BLOCK; i++) begin
        carry[k*BLOCK+i] = c;
        c = s1_g[k*BLOCK+i] | (s1_p[k*BLOCK+i] & c);
      end
      cb   = s1_bgg[k] | (s1_bpg[k] & cb);
      w_pg = w_pg & s1_bpg[k];
      w_gg = (w_gg & s1_bpg[k]) | s1_bgg[k];
    end
    c_out_d = (s1_cin & w_pg) | w_gg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      io_out_valid <= 1'b0;
      io_out_s     <= '0;
      io_out_c_out <= 1'b0;
      io_out_pg    <= 1'b0;
      io_out_gg    <= 1'b0;
      io_out_ovf   <= 1'b0;
    end else begin
      if (io_in_ready)
        s1_valid <= io_in_valid;
      if (stage1_advance) begin
        io_out_valid <= s1_valid;
        if (s1_valid) begin
          io_out_s     <= s1_x ^ carry;
          io_out_c_out <= c_out_d;
          io_out_pg    <= w_pg;
          io_out_gg    <= w_gg;
          io_out_ovf   <= carry[WIDTH-1] ^ c_out_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: 8/4 directed + random, 64/8 random.
// Arithmetic model with per-cycle scoreboard compare on each instance.
module tb_pipelined_cla_adder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic       v8, rdy8, c8, ov8, or8;
  logic       co8, pg8, gg8, ovf8, sub8;
  logic [7:0] a8, b8, s8;

  logic        v64, rdy64, c64, ov64, or64;
  logic        co64, pg64, gg64, ovf64, sub64;
  logic [63:0] a64, b64, s64;

  int total = 0;
  int bad   = 0;

  logic start64 = 1'b0;
  logic done64  = 1'b0;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        pg;
    logic        gg;
    logic        ovf;
  } res_t;

  res_t q8[$];
  res_t q64[$];

  pipelined_cla_adder #(.WIDTH(8), .BLOCK(4)) u8 (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (v8),
    .io_in_ready  (rdy8),
    .io_in_a      (a8),
    .io_in_b      (b8),
    .io_in_c_in   (c8),
`ifdef PIPELINED_CLA_SUB_EN
    .io_in_sub    (sub8),
`endif
    .io_out_valid (ov8),
    .io_out_ready (or8),
    .io_out_s     (s8),
    .io_out_c_out (co8),
    .io_out_pg    (pg8),
    .io_out_gg    (gg8),
    .io_out_ovf   (ovf8)
  );

  pipelined_cla_adder #(.WIDTH(64), .BLOCK(8)) u64 (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (v64),
    .io_in_ready  (rdy64),
    .io_in_a      (a64),
    .io_in_b      (b64),
    .io_in_c_in   (c64),
`ifdef PIPELINED_CLA_SUB_EN
    .io_in_sub    (sub64),
`endif
    .io_out_valid (ov64),
    .io_out_ready (or64),
    .io_out_s     (s64),
    .io_out_c_out (co64),
    .io_out_pg    (pg64),
    .io_out_gg    (gg64),
    .io_out_ovf   (ovf64)
  );

  // Plain-arithmetic reference: gg is the carry out with c_in = 0.
  function automatic res_t model(input int w,
                                 input logic [63:0] a,
                                 input logic [63:0] b,
                                 input logic c,
                                 input logic sub);
    logic [64:0] h, f;
    logic [63:0] mask, bb;
    logic        cc;
    res_t        r;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb    = sub ? (~b & mask) : b;
    cc    = sub ? 1'b1 : c;
    h     = {1'b0, a} + {1'b0, bb};
    f     = h + {64'd0, cc};
    r.s   = f[63:0] & mask;
    r.co  = f[w];
    r.gg  = h[w];
    r.pg  = ((a | bb) & mask) == mask;
    r.ovf = (a[w-1] == bb[w-1]) && (r.s[w-1] != a[w-1]);
    return r;
  endfunction

  task automatic chk(input string n,
                     input logic [67:0] got,
                     input logic [67:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  logic held8;
  res_t prev8;
  always @(negedge clock) begin
    res_t cur;
    cur = {56'd0, s8, co8, pg8, gg8, ovf8};
    if (reset) begin
      q8.delete();
      held8 = 1'b0;
    end else begin
      if (held8)
        chk("hold8", cur, prev8);
      if (ov8 && or8) begin
        if (q8.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious8 got=%h exp=none", cur);
        end else begin
          chk("out8", cur, q8.pop_front());
        end
      end
      held8 = ov8 && !or8;
      prev8 = cur;
      if (v8 && rdy8)
        q8.push_back(model(8, {56'd0, a8}, {56'd0, b8}, c8, sub8));
    end
  end

  logic held64;
  res_t prev64;
  always @(negedge clock) begin
    res_t cur;
    cur = {s64, co64, pg64, gg64, ovf64};
    if (reset) begin
      q64.delete();
      held64 = 1'b0;
    end else begin
      if (held64)
        chk("hold64", cur, prev64);
      if (ov64 && or64) begin
        if (q64.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious64 got=%h exp=none", cur);
        end else begin
          chk("out64", cur, q64.pop_front());
        end
      end
      held64 = ov64 && !or64;
      prev64 = cur;
      if (v64 && rdy64)
        q64.push_back(model(64, a64, b64, c64, sub64));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    v8 = 1'b0;
    repeat (n) step();
  endtask

  task automatic send8(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic c,
                       input logic sub);
    a8   = a;
    b8   = b;
    c8   = c;
    sub8 = sub;
    v8   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rdy8) begin
        step();
        v8 = 1'b0;
        return;
      end
    end
    v8 = 1'b0;
    chk("send8_timeout", 68'd0, 68'd1);
  endtask

  logic [7:0] ta[3];
  logic [7:0] tb[3];
  logic       tc[3];
  int         idx;
  logic       acc;

  task automatic stream8(input int cycles);
    v8 = 1'b1;
    for (int cyc = 0; cyc < cycles && idx < 3; cyc++) begin
      a8 = ta[idx];
      b8 = tb[idx];
      c8 = tc[idx];
      @(negedge clock);
      acc = rdy8;
      step();
      if (acc) idx++;
    end
  endtask

  initial begin
    reset = 1'b1;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0; or8 = 1; sub8 = 0;
    repeat (3) step();
    reset = 1'b0;

    chk("rst_out_valid", ov8, 0);
    chk("rst_in_ready", rdy8, 1);
    chk("rst_s", s8, 0);
    chk("rst_c_out", co8, 0);
    chk("rst_pg", pg8, 0);
    chk("rst_gg", gg8, 0);
    chk("rst_ovf", ovf8, 0);

    send8(8'hFF, 8'h01, 1'b0, 1'b0);
    chk("lat_one_cycle", ov8, 0);
    step();
    chk("ff01_valid", ov8, 1);
    chk("ff01_s", s8, 8'h00);
    chk("ff01_c_out", co8, 1);
    chk("ff01_pg", pg8, 1);
    chk("ff01_gg", gg8, 1);
    chk("ff01_ovf", ovf8, 0);

    send8(8'h7F, 8'h01, 1'b0, 1'b0);
    step();
    chk("7f01_s", s8, 8'h80);
    chk("7f01_c_out", co8, 0);
    chk("7f01_ovf", ovf8, 1);

    send8(8'h80, 8'h80, 1'b0, 1'b0);
    step();
    chk("8080_s", s8, 8'h00);
    chk("8080_c_out", co8, 1);
    chk("8080_ovf", ovf8, 1);
    idle(3);

    ta = '{8'h11, 8'h33, 8'hF0};
    tb = '{8'h22, 8'h44, 8'h0F};
    tc = '{1'b0, 1'b1, 1'b1};
    idx = 0;
    or8 = 1'b0;
    stream8(4);
    chk("stall_accepted", idx, 2);
    chk("stall_in_ready", rdy8, 0);
    chk("stall_valid", ov8, 1);
    chk("stall_s", s8, 8'h33);
    or8 = 1'b1;
    stream8(10);
    chk("stall_all_in", idx, 3);
    idle(5);
    chk("stall_drained", q8.size(), 0);

    ta = '{8'h01, 8'h03, 8'h05};
    tb = '{8'h02, 8'h04, 8'h06};
    tc = '{1'b0, 1'b0, 1'b0};
    idx = 0;
    or8 = 1'b0;
    stream8(2);
    chk("flush_loaded", idx, 2);
    v8 = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("flush_valid", ov8, 0);
    chk("flush_ready", rdy8, 1);
    or8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush_no_out", ov8, 0);
    end

`ifdef PIPELINED_CLA_SUB_EN
    send8(8'h05, 8'h07, 1'b0, 1'b1);
    step();
    chk("sub_s", s8, 8'hFE);
    chk("sub_c_out", co8, 0);
    chk("sub_ovf", ovf8, 0);
    idle(3);
`endif

    start64 = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
`ifdef PIPELINED_CLA_SUB_EN
      sub8 = 1'($urandom);
`endif
      v8  = 1'($urandom);
      or8 = ($urandom % 4) != 0;
      step();
    end
    or8 = 1'b1;
    idle(5);
    chk("drain8", q8.size(), 0);

    for (int i = 0; i < 60000 && !done64; i++)
      step();
    if (!done64)
      chk("timeout64", 68'd0, 68'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    v64 = 0; a64 = 0; b64 = 0; c64 = 0;
    or64 = 1; sub64 = 0;
    n = 0;
    wait (start64);
    for (int cyc = 0; cyc < 50000 && n < 10000; cyc++) begin
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      c64 = 1'($urandom);
`ifdef PIPELINED_CLA_SUB_EN
      sub64 = 1'($urandom);
`endif
      v64  = ($urandom % 4) != 0;
      or64 = ($urandom % 4) != 0;
      @(negedge clock);
      if (v64 && rdy64) n++;
      step();
    end
    v64  = 1'b0;
    or64 = 1'b1;
    repeat (5) step();
    chk("count64", n, 10000);
    chk("drain64", q64.size(), 0);
    done64 = 1'b1;
  end

endmodule
